// File: rtl/setpoint_pkg.sv
// rtl/setpoint_pkg.sv - shared constants and mode type for the setpoint counter
package setpoint_pkg;

    // Default DPWM current-code window and step
    localparam int SP_STEP    = 50;
    localparam int SP_MIN_VAL = 0;
    localparam int SP_MAX_VAL = 1000;

    typedef enum logic {
        MODE_SAT  = 1'b0,
        MODE_WRAP = 1'b1
    } setpoint_mode_e;

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizer, debounce counter and press-edge pulse for one raw button
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [1:0]    vld_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          armed_q, armed_d;

    // Two-flop synchronizer plus a marker of when its output holds a real sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYCLES consecutive differing samples.
    // Presses are armed only once the button has been seen released, so a
    // button held through reset does not produce an event.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        armed_d = armed_q | (vld_q[1] & ~sync2_q & ~level_q);
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            armed_q      <= armed_d;
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~level_prev_q & armed_q;

endmodule

// File: rtl/setpoint_updown_counter.sv
// rtl/setpoint_updown_counter.sv - button-driven up/down setpoint counter; optional auto-repeat under SETPOINT_AUTOREPEAT_EN
module setpoint_updown_counter
    import setpoint_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int STEP            = SP_STEP,
    parameter int MIN_VAL         = SP_MIN_VAL,
    parameter int MAX_VAL         = SP_MAX_VAL,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000000,
    parameter int REPEAT_PERIOD   = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             btn_up_i,
    input  logic             btn_dn_i,
    input  logic             wrap_mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_max_o,
    output logic             at_min_o,
    output logic             step_pulse_o
);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MIN_W  = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_W  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_C = STEP_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_C  = MIN_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_C  = MAX_W[WIDTH-1:0];

    logic           lvl_up, lvl_dn, press_up, press_dn;
    logic           up_ev, dn_ev;
    logic [WIDTH-1:0] count_q, count_d;
    logic           step_q;
    logic [WIDTH:0] sum;
    setpoint_mode_e mode;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_up (
        .clk(clk), .reset(reset), .btn_i(btn_up_i), .level_o(lvl_up), .press_o(press_up)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dn (
        .clk(clk), .reset(reset), .btn_i(btn_dn_i), .level_o(lvl_dn), .press_o(press_dn)
    );

`ifdef SETPOINT_AUTOREPEAT_EN
    logic        rep_run_q, rep_dir_q, rep_first_q;
    logic [31:0] rep_cnt_q;
    logic        rep_active, rep_fire;

    assign rep_active = rep_run_q & enable_i &
                        (rep_dir_q ? (lvl_up & ~lvl_dn) : (lvl_dn & ~lvl_up));
    assign rep_fire   = rep_active &
                        (rep_cnt_q == (rep_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD)));

    // Repeat timer: restarts on an accepted press, stops as soon as the hold is broken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_run_q   <= 1'b0;
            rep_dir_q   <= 1'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end else if (enable_i && (press_up ^ press_dn)) begin
            rep_run_q   <= 1'b1;
            rep_dir_q   <= press_up;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= 32'd1;
        end else if (rep_active) begin
            if (rep_fire) begin
                rep_first_q <= 1'b0;
                rep_cnt_q   <= 32'd1;
            end else begin
                rep_cnt_q   <= rep_cnt_q + 32'd1;
            end
        end else begin
            rep_run_q   <= 1'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end
    end

    assign up_ev = press_up | (rep_fire & rep_dir_q);
    assign dn_ev = press_dn | (rep_fire & ~rep_dir_q);
`else
    logic unused_repeat;
    assign unused_repeat = lvl_up ^ lvl_dn ^ (REPEAT_DELAY != REPEAT_PERIOD);
    assign up_ev = press_up;
    assign dn_ev = press_dn;
`endif

    assign mode = setpoint_mode_e'(wrap_mode_i);

    // Update rule: step, then saturate or wrap at the window limits
    always_comb begin
        count_d = count_q;
        sum     = {1'b0, count_q} + STEP_W;
        if (enable_i && up_ev && !dn_ev) begin
            if (sum <= MAX_W) begin
                count_d = sum[WIDTH-1:0];
            end else begin
                count_d = (mode == MODE_WRAP) ? MIN_C : MAX_C;
            end
        end else if (enable_i && dn_ev && !up_ev) begin
            if ({1'b0, count_q} >= MIN_W + STEP_W) begin
                count_d = count_q - STEP_C;
            end else begin
                count_d = (mode == MODE_WRAP) ? MAX_C : MIN_C;
            end
        end
    end

    // Count register and change pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= MIN_C;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            step_q  <= (count_d != count_q);
        end
    end

    assign count_o      = count_q;
    assign step_pulse_o = step_q;
    assign at_max_o     = (count_q == MAX_C);
    assign at_min_o     = (count_q == MIN_C);

endmodule

// File: tb/tb_setpoint_updown_counter.sv
// tb/tb_setpoint_updown_counter.sv - directed self-checking bench for setpoint_updown_counter
module tb_setpoint_updown_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1, rst2 = 1'b1;
    logic       enable = 1'b1, btn_up = 1'b0, btn_dn = 1'b0, wrap = 1'b0;
    logic       enable2 = 1'b1, btn_up2 = 1'b0, btn_dn2 = 1'b0, wrap2 = 1'b0;
    logic [9:0] count, count2;
    logic       at_max, at_min, pulse, at_max2, at_min2, pulse2;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    setpoint_updown_counter #(
        .WIDTH(10), .STEP(50), .MIN_VAL(0), .MAX_VAL(1000),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .btn_up_i(btn_up), .btn_dn_i(btn_dn),
        .wrap_mode_i(wrap), .count_o(count), .at_max_o(at_max), .at_min_o(at_min),
        .step_pulse_o(pulse)
    );

    setpoint_updown_counter #(
        .WIDTH(10), .STEP(50), .MIN_VAL(100), .MAX_VAL(230),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut2 (
        .clk(clk), .reset(rst2), .enable_i(enable2), .btn_up_i(btn_up2), .btn_dn_i(btn_dn2),
        .wrap_mode_i(wrap2), .count_o(count2), .at_max_o(at_max2), .at_min_o(at_min2),
        .step_pulse_o(pulse2)
    );

    task automatic do_press(input logic up, input logic dn, output int pulses);
        pulses = 0;
        @(posedge clk); #1;
        btn_up = up; btn_dn = dn;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pulse) pulses++;
            if (i == 9) begin btn_up = 1'b0; btn_dn = 1'b0; end
        end
    endtask

    task automatic do_press2(input logic up, input logic dn, output int pulses);
        pulses = 0;
        @(posedge clk); #1;
        btn_up2 = up; btn_dn2 = dn;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pulse2) pulses++;
            if (i == 9) begin btn_up2 = 1'b0; btn_dn2 = 1'b0; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; rst2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 10'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if ({at_min, at_max, pulse} !== 3'b100) $display("FAIL reset_flags got %b want 100", {at_min, at_max, pulse}); else n_pass++;
        n_checks++; if (count2 !== 10'd100) $display("FAIL reset_count2 got %0d want 100", count2); else n_pass++;
        reset = 1'b0; rst2 = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_first_press;
        int pulses = 0;
        @(posedge clk); #1;
        btn_up = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (pulse) pulses++;
            if (e == 6) begin
                n_checks++; if (count !== 10'd0) $display("FAIL first_edge6 got %0d want 0", count); else n_pass++;
            end
            if (e == 7) begin
                n_checks++; if (count !== 10'd50) $display("FAIL first_edge7 got %0d want 50", count); else n_pass++;
                n_checks++; if ({pulse, at_min} !== 2'b10) $display("FAIL first_flags got %b want 10", {pulse, at_min}); else n_pass++;
            end
        end
        btn_up = 1'b0;
        repeat (16) @(posedge clk);
        n_checks++; if (pulses != 1) $display("FAIL first_pulses got %0d want 1", pulses); else n_pass++;
    endtask

    task automatic test_saturate_max;
        int p;
        for (int i = 0; i < 19; i++) do_press(1'b1, 1'b0, p);
        n_checks++; if (count !== 10'd1000) $display("FAIL sat_count got %0d want 1000", count); else n_pass++;
        n_checks++; if ({at_max, at_min} !== 2'b10) $display("FAIL sat_flags got %b want 10", {at_max, at_min}); else n_pass++;
        do_press(1'b1, 1'b0, p);
        n_checks++; if (count !== 10'd1000) $display("FAIL sat_hold got %0d want 1000", count); else n_pass++;
        n_checks++; if (p != 0) $display("FAIL sat_pulse got %0d want 0", p); else n_pass++;
    endtask

    task automatic test_wrap;
        int p;
        wrap = 1'b1;
        do_press(1'b1, 1'b0, p);
        n_checks++; if (count !== 10'd0 || p != 1) $display("FAIL wrap_up got %0d/%0d want 0/1", count, p); else n_pass++;
        n_checks++; if (at_min !== 1'b1) $display("FAIL wrap_at_min got %b want 1", at_min); else n_pass++;
        do_press(1'b0, 1'b1, p);
        n_checks++; if (count !== 10'd1000 || p != 1) $display("FAIL wrap_dn got %0d/%0d want 1000/1", count, p); else n_pass++;
        wrap = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 10'd1000) $display("FAIL mode_change got %0d want 1000", count); else n_pass++;
    endtask

    task automatic test_reject;
        int p;
        int pulses = 0;
        do_press(1'b0, 1'b1, p);
        n_checks++; if (count !== 10'd950) $display("FAIL sat_dn got %0d want 950", count); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            btn_up = ((i % 6) < 3);
        end
        btn_up = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 10'd950) $display("FAIL bounce got %0d want 950", count); else n_pass++;
        do_press(1'b1, 1'b1, p);
        n_checks++; if (count !== 10'd950 || p != 0) $display("FAIL both got %0d/%0d want 950/0", count, p); else n_pass++;
        enable = 1'b0;
        do_press(1'b1, 1'b0, p);
        n_checks++; if (count !== 10'd950 || p != 0) $display("FAIL disabled got %0d/%0d want 950/0", count, p); else n_pass++;
        @(posedge clk); #1;
        btn_up = 1'b1;
        repeat (15) @(posedge clk);
        #1 enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pulse) pulses++;
        end
        btn_up = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 10'd950 || pulses != 0) $display("FAIL held_enable got %0d/%0d want 950/0", count, pulses); else n_pass++;
        do_press(1'b1, 1'b0, p);
        n_checks++; if (count !== 10'd1000) $display("FAIL reenabled got %0d want 1000", count); else n_pass++;
    endtask

    task automatic test_limits_and_reset;
        int p;
        int pulses = 0;
        do_press2(1'b1, 1'b0, p);
        do_press2(1'b1, 1'b0, p);
        n_checks++; if (count2 !== 10'd200) $display("FAIL lim_200 got %0d want 200", count2); else n_pass++;
        do_press2(1'b1, 1'b0, p);
        n_checks++; if (count2 !== 10'd230 || p != 1) $display("FAIL lim_sat got %0d/%0d want 230/1", count2, p); else n_pass++;
        n_checks++; if (at_max2 !== 1'b1) $display("FAIL lim_at_max got %b want 1", at_max2); else n_pass++;
        @(posedge clk); #1;
        btn_up2 = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst2 = 1'b1;
        #1;
        n_checks++; if (count2 !== 10'd100) $display("FAIL async_reset got %0d want 100", count2); else n_pass++;
        n_checks++; if ({at_min2, at_max2, pulse2} !== 3'b100) $display("FAIL async_flags got %b want 100", {at_min2, at_max2, pulse2}); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (pulse2) pulses++;
        end
        n_checks++; if (count2 !== 10'd100 || pulses != 0) $display("FAIL held_after_reset got %0d/%0d want 100/0", count2, pulses); else n_pass++;
        btn_up2 = 1'b0;
        repeat (16) @(posedge clk);
        do_press2(1'b1, 1'b0, p);
        n_checks++; if (count2 !== 10'd150 || p != 1) $display("FAIL repress got %0d/%0d want 150/1", count2, p); else n_pass++;
    endtask

`ifdef SETPOINT_AUTOREPEAT_EN
    task automatic test_repeat;
        int exp_count = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 btn_up = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 7 || e == 27 || e == 35 || e == 43 || e == 51 || e == 59) exp_count += 50;
            n_checks++;
            if (count !== 10'(exp_count)) $display("FAIL repeat_edge%0d got %0d want %0d", e, count, exp_count); else n_pass++;
        end
        btn_up = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (count !== 10'd300) $display("FAIL repeat_final got %0d want 300", count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_first_press();
        test_saturate_max();
        test_wrap();
        test_reject();
        test_limits_and_reset();
`ifdef SETPOINT_AUTOREPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/setpoint_updown_counter.md
# setpoint_updown_counter

Parametrised, synchronous up/down setpoint counter driven by two raw push-buttons. Each button goes through a synchronizer, a debouncer and a rising-edge detector. Each accepted press moves the count by a configurable step inside a configurable [MIN_VAL, MAX_VAL] window, with a runtime choice of wrap or saturate at the limits. The block sits between the board buttons and the DPWM current-select logic and supplies the current setpoint code.

## Interface
- WIDTH, 10: count width in bits.
- STEP, 50: increment/decrement per accepted press.
- MIN_VAL, 0: lowest legal count. This is also the reset value.
- MAX_VAL, 1000: highest legal count. Must be < 2^WIDTH, with MIN_VAL < MAX_VAL.
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles needed to accept a level change. Must be ≥ 1.
- REPEAT_DELAY, 1000000: hold time before auto-repeat starts. Used only with the macro.
- REPEAT_PERIOD, 250000: auto-repeat interval. Used only with the macro.
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- enable_i  in  1  when low, accepted presses are discarded, not queued.
- btn_up_i  in  1  raw, asynchronous up button.
- btn_dn_i  in  1  raw, asynchronous down button.
- wrap_mode_i  in  1  1 = wrap at the limits, 0 = saturate.
- count_o  out  WIDTH  current setpoint.
- at_max_o  out  1  high when count_o == MAX_VAL.
- at_min_o  out  1  high when count_o == MIN_VAL.
- step_pulse_o  out  1  one-cycle pulse in the cycle after count_o changed.

## Operation
- **Conditioner (per button):**
  - 2-flop synchronizer feeds a debounce counter.
  - Debounced level flips once the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch back to the old level clears the counter.
  - A press event is a one-cycle pulse on a debounced rising edge. Releases generate no event.
- **Update rule,** evaluated each cycle when enable_i = 1. Arithmetic is done in WIDTH+1 bits, so the sum never overflows.
  - Up only: if count + STEP ≤ MAX_VAL, then count += STEP. Otherwise count = MAX_VAL when saturating, or MIN_VAL when wrapping.
  - Down only: if count ≥ MIN_VAL + STEP, then count −= STEP. Otherwise count = MIN_VAL when saturating, or MAX_VAL when wrapping.
  - Up and down in the same cycle: no change, and no step_pulse_o.
- **Saturate at a limit:** a press that would leave the count unchanged produces no step_pulse_o.
- **Mode changes:** wrap_mode_i is sampled in the same cycle as the press event. Changing it never alters count_o by itself.
- **enable_i low:** press events are dropped. The conditioners keep tracking, so a button held across the enable rising edge does not step.
- **Flags:** at_max_o and at_min_o are combinational compares on the count register.

## Timing
- **Reset values:** count_o = MIN_VAL, at_min_o = 1, at_max_o = 0, step_pulse_o = 0. All synchronizer, debounce and repeat state clears.
- **Reset mid-operation:** asserting reset during a press or debounce clears everything immediately. A button still held after reset releases does not step until it has been released and pressed again.
- **Press latency:** count_o changes on rising clk edge DEBOUNCE_CYCLES + 3 after the raw input rises, provided the input stays stable. step_pulse_o is high for the following cycle.
- **Release:** takes DEBOUNCE_CYCLES + 2 edges to propagate to the debounced level.
- **Minimum gap between accepted presses:** 2·DEBOUNCE_CYCLES + 4 cycles, covering release plus a new press.

## Configuration
- **SETPOINT_AUTOREPEAT_EN defined:**
  - While one button's debounced level stays high with enable_i = 1, a repeat event fires REPEAT_DELAY cycles after the initial press event, then every REPEAT_PERIOD cycles.
  - Repeat events follow the same update rule as a press.
  - Repeat stops immediately on release, when the other button goes high, or when enable_i goes low.
- **Macro not defined:** exactly one step per press. The repeat counters and REPEAT_* parameters are unused, and no repeat logic is synthesised.

## Structure
- **Shared package setpoint_pkg:**
  - Default constants STEP, MIN_VAL and MAX_VAL for DPWM current codes.
  - typedef for the wrap/saturate mode enum (MODE_SAT = 0, MODE_WRAP = 1).
- **One sub-module, button_conditioner:** synchronizer, debounce counter and edge pulse. Parameter DEBOUNCE_CYCLES; outputs level_o and press_o. Instantiated twice.
- **Top level:** holds the update rule, the flags and the optional repeat timer.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4. For the last scenario, REPEAT_DELAY = 20 and REPEAT_PERIOD = 8.
- Release reset, then hold btn_up_i for 20 cycles → count_o goes 0 → 50 exactly on edge 7, step_pulse_o pulses once, at_min_o falls.
- 20 clean up presses with wrap_mode_i = 0 → count_o = 1000 and at_max_o = 1. A 21st press → count stays at 1000, no pulse.
- wrap_mode_i = 1 at 1000, one up press → count_o = 0. One down press → count_o = 1000.
- Bounce btn_up_i with 3-cycle highs for 40 cycles → no change. Press both buttons together → no change. Press with enable_i = 0 → no change.
- MIN_VAL = 100, MAX_VAL = 230, STEP = 50, saturate, from 200, up press → 230. Reset asserted during a later press → count_o = 100 immediately, no step until the button is released and pressed again.
- With SETPOINT_AUTOREPEAT_EN, hold btn_up_i 60 cycles from 0 → steps at edges 7, 27, 35, 43, 51, 59, giving count_o = 300.
